// File: rtl/ov7670_pkg.sv
// OV7670 configuration shared definitions: setup ROM markers,
// sequencer state encoding and the camera's SCCB device ID.
package ov7670_pkg;

    localparam logic [15:0] ROM_END        = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY      = 16'hFFF0;
    localparam logic [7:0]  ROM_LAST_IDX   = 8'hFF;
    localparam logic [7:0]  OV7670_SCCB_ID = 8'h42;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_ISSUE   = 4'd3;
    localparam logic [3:0] S_WAIT_LO = 4'd4;
    localparam logic [3:0] S_WAIT_HI = 4'd5;
    localparam logic [3:0] S_DELAY   = 4'd6;
    localparam logic [3:0] S_NEXT    = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE    = S_IDLE,
        ST_FETCH   = S_FETCH,
        ST_DECODE  = S_DECODE,
        ST_ISSUE   = S_ISSUE,
        ST_WAIT_LO = S_WAIT_LO,
        ST_WAIT_HI = S_WAIT_HI,
        ST_DELAY   = S_DELAY,
        ST_NEXT    = S_NEXT,
        ST_DONE    = S_DONE
    } cfg_state_e;

    function automatic logic is_busy(input cfg_state_e s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Delay counter for the configuration sequencer: clears on request,
// counts while enabled, flags the last cycle of a TERMINAL-cycle wait.
module cfg_delay_timer
    import ov7670_pkg::*;
#(
    parameter int CNT_W    = 18,
    parameter int TERMINAL = 250_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/ov7670_config_ctrl.sv
// OV7670 setup sequencer: walks the setup ROM from index 0 and issues
// one SCCB register write per entry, honouring delay and end markers.
module ov7670_config_ctrl
    import ov7670_pkg::*;
#(
    parameter int DELAY_CYCLES = 250_000,
    parameter int CNT_W        = 18
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic [7:0]  o_rom_select,
    input  logic [15:0] i_rom_out,
    input  logic        i_sccb_ready,
    input  logic        i_sccb_nack,
    output logic        o_sccb_start,
    output logic [7:0]  o_sccb_addr,
    output logic [7:0]  o_sccb_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    cfg_state_e r_state;
    cfg_state_e w_state_nxt;

    logic [7:0] r_rom_select;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic       r_sccb_start;
    logic       r_busy;
    logic       r_done;
    logic       r_err;

    logic [7:0] w_sel_nxt;
    logic [7:0] w_addr_nxt;
    logic [7:0] w_data_nxt;
    logic       w_start_nxt;
    logic       w_err_nxt;
    logic       w_tmr_clr;
    logic       w_tmr_en;
    logic       w_tmr_tc;

    cfg_delay_timer #(
        .CNT_W    (CNT_W),
        .TERMINAL (DELAY_CYCLES)
    ) u_delay (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_tmr_clr),
        .i_en  (w_tmr_en),
        .o_tc  (w_tmr_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_rom_select;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_start_nxt = 1'b0;
        w_err_nxt   = r_err;
        w_tmr_clr   = 1'b0;
        w_tmr_en    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_FETCH;
                    w_sel_nxt   = 8'h00;
                    w_err_nxt   = 1'b0;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                unique case (1'b1)
                    (i_rom_out == ROM_END): begin
                        w_state_nxt = ST_DONE;
                    end
                    (i_rom_out == ROM_DELAY): begin
                        w_state_nxt = ST_DELAY;
                        w_tmr_clr   = 1'b1;
                    end
                    default: begin
                        w_state_nxt = ST_ISSUE;
                        w_addr_nxt  = i_rom_out[15:8];
                        w_data_nxt  = i_rom_out[7:0];
                    end
                endcase
            end
            ST_ISSUE: begin
                if (i_sccb_ready) begin
                    w_start_nxt = 1'b1;
                    w_state_nxt = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!i_sccb_ready) begin
                    w_state_nxt = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (i_sccb_ready) begin
                    w_err_nxt   = r_err | i_sccb_nack;
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_DELAY: begin
                w_tmr_en = 1'b1;
                if (w_tmr_tc) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (r_rom_select == ROM_LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_sel_nxt   = r_rom_select + 8'd1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DONE: begin
                if (i_start) begin
                    w_state_nxt = ST_FETCH;
                    w_sel_nxt   = 8'h00;
                    w_err_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // rst wins over a coincident start; an in-flight write is abandoned
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_rom_select <= 8'h00;
            r_addr       <= 8'h00;
            r_data       <= 8'h00;
            r_sccb_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rom_select <= w_sel_nxt;
            r_addr       <= w_addr_nxt;
            r_data       <= w_data_nxt;
            r_sccb_start <= w_start_nxt;
            r_busy       <= is_busy(w_state_nxt);
            r_done       <= (w_state_nxt == ST_DONE);
            r_err        <= w_err_nxt;
        end
    end

    assign o_rom_select = r_rom_select;
    assign o_sccb_start = r_sccb_start;
    assign o_sccb_addr  = r_addr;
    assign o_sccb_data  = r_data;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_ov7670_config_ctrl.sv
// Scoreboard bench for ov7670_config_ctrl: ROM and SCCB master models,
// expected writes derived from the ROM table by a reference walk.
module tb_ov7670_config_ctrl;

    localparam int DLY = 16;
    localparam int CW  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_sel;
    logic [15:0] rom_q = 16'h0000;
    logic        ready = 1'b1;
    logic        nack = 1'b0;
    logic        s_start;
    logic [7:0]  s_addr;
    logic [7:0]  s_data;
    logic        busy;
    logic        done;
    logic        err;

    ov7670_config_ctrl #(
        .DELAY_CYCLES (DLY),
        .CNT_W        (CW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .o_rom_select (rom_sel),
        .i_rom_out    (rom_q),
        .i_sccb_ready (ready),
        .i_sccb_nack  (nack),
        .o_sccb_start (s_start),
        .o_sccb_addr  (s_addr),
        .o_sccb_data  (s_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         gap;
        bit         from_start;
    } wr_t;

    logic [15:0] rom [256];
    wr_t         exp_q[$];
    bit          nack_plan [257];

    int ncheck = 0;
    int nfail  = 0;
    int cyc    = 0;
    int t_start = 0;
    int t_ret   = 0;
    int nwr     = 0;
    int nack_base  = 0;
    int hold_until = 0;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    always @(posedge clk) rom_q <= rom[rom_sel];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        ncheck++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // SCCB master model: drops ready on start, random busy time, nack per plan
    initial begin : sccb_master
        bit         m_busy;
        int         m_left;
        int         idx;
        logic [7:0] m_a;
        logic [7:0] m_d;
        m_busy = 0;
        m_left = 0;
        m_a = 8'h00;
        m_d = 8'h00;
        forever begin
            @(negedge clk);
            nack = 1'b0;
            if (cyc < hold_until) begin
                ready  = 1'b0;
                m_busy = 0;
            end else if (rst) begin
                ready  = 1'b1;
                m_busy = 0;
            end else if (!m_busy) begin
                ready = 1'b1;
                if (s_start) begin
                    m_busy = 1;
                    m_a    = s_addr;
                    m_d    = s_data;
                    m_left = $urandom_range(4, 0);
                    ready  = 1'b0;
                    nwr++;
                end
            end else begin
                chk("addr_stable", {24'd0, s_addr}, {24'd0, m_a});
                chk("data_stable", {24'd0, s_data}, {24'd0, m_d});
                if (m_left == 0) begin
                    idx = nwr - nack_base;
                    ready = 1'b1;
                    if (idx >= 1 && idx <= 256) nack = nack_plan[idx];
                    t_ret  = cyc;
                    m_busy = 0;
                end else begin
                    m_left--;
                end
            end
        end
    end

    initial begin : monitor
        logic prev_start;
        wr_t  e;
        int   ref_t;
        prev_start = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (s_start === 1'b1) begin
                chk("start_while_ready", {31'd0, ready}, 32'd1);
                chk("start_one_cycle", {31'd0, prev_start}, 32'd0);
                if (exp_q.size() == 0) begin
                    ncheck++;
                    nfail++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected none",
                             s_addr, s_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", {24'd0, s_addr}, {24'd0, e.a});
                    chk("write_data", {24'd0, s_data}, {24'd0, e.d});
                    if (e.gap >= 0) begin
                        ref_t = e.from_start ? t_start : t_ret;
                        chk("write_gap", cyc - ref_t, e.gap);
                    end
                end
            end
            prev_start = s_start;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_rom_select"}, {24'd0, rom_sel}, 32'd0);
        chk({tag, "_sccb_start"}, {31'd0, s_start}, 32'd0);
        chk({tag, "_sccb_addr"}, {24'd0, s_addr}, 32'd0);
        chk({tag, "_sccb_data"}, {24'd0, s_data}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        if (hold > 0) hold_until = cyc + hold;
        exp_q.delete();
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        for (int i = 0; i < 257; i++) nack_plan[i] = 0;
    endtask

    // Reference walk of the ROM table, start pulse, then end-of-run checks
    task automatic run_seq(input string tag, input bit gap_first, input bit poke);
        int  nd;
        int  n;
        int  end_idx;
        int  base;
        bit  first;
        bit  e_err;
        int  k;
        wr_t w;
        nd = 0;
        n = 0;
        first = 1;
        e_err = 0;
        end_idx = 255;
        for (int i = 0; i < 256; i++) begin
            if (rom[i] == 16'hFFFF) begin
                end_idx = i;
                break;
            end
            if (rom[i] == 16'hFFF0) begin
                nd++;
                continue;
            end
            w.a = rom[i][15:8];
            w.d = rom[i][7:0];
            w.from_start = first;
            if (first) w.gap = gap_first ? 4 + nd * (3 + DLY) : -1;
            else w.gap = 5 + nd * (3 + DLY);
            exp_q.push_back(w);
            first = 0;
            nd = 0;
            n++;
            e_err |= nack_plan[n];
        end
        base = nwr;
        nack_base = base;
        @(negedge clk);
        start = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_at_start"}, {31'd0, busy}, 32'd1);
        chk({tag, "_done_at_start"}, {31'd0, done}, 32'd0);
        chk({tag, "_err_at_start"}, {31'd0, err}, 32'd0);
        if (poke) begin
            for (k = 0; k < 2000 && (nwr - base) < 1; k++) @(negedge clk);
            chk({tag, "_poke_reached"}, {31'd0, busy}, 32'd1);
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (k = 0; k < 30000; k++) begin
            if (done) break;
            @(negedge clk);
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_err_end"}, {31'd0, err}, {31'd0, e_err});
        chk({tag, "_write_count"}, nwr - base, n);
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_rom_select_end"}, {24'd0, rom_sel}, end_idx);
        exp_q.delete();
    endtask

    initial begin : stimulus
        int  base;
        bit  hit;
        int  len;
        int  r;
        logic [15:0] v;
        wr_t w;

        clear_tables();
        do_reset(0);
        @(negedge clk);
        check_zero("reset");

        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1214;
        run_seq("basic", 1, 0);

        do_reset(5);
        run_seq("ready_hold", 0, 0);

        clear_tables();
        rom[0] = 16'h1280; rom[1] = 16'h1214; rom[2] = 16'hFFF0;
        rom[3] = 16'h3A04;
        nack_plan[2] = 1;
        run_seq("nack", 1, 0);
        nack_plan[2] = 0;
        run_seq("restart", 1, 0);

        clear_tables();
        rom[0] = 16'h1280; rom[1] = 16'h1214; rom[2] = 16'h1100;
        rom[3] = 16'hFF12; rom[4] = 16'h40D0;
        run_seq("busy_start", 1, 1);

        base = nwr;
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        chk("rst_start_done", {31'd0, done}, 32'd0);
        chk("rst_start_writes", nwr - base, 0);

        w.a = 8'h12; w.d = 8'h80; w.gap = 4; w.from_start = 1;
        exp_q.push_back(w);
        w.a = 8'h12; w.d = 8'h14; w.gap = 5; w.from_start = 0;
        exp_q.push_back(w);
        base = nwr;
        nack_base = base;
        @(negedge clk);
        start = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        fork
            begin
                wait ((nwr - base) == 2);
                hit = 1;
            end
            begin
                repeat (3000) @(posedge clk);
            end
        join_any
        disable fork;
        chk("mid_reset_reached", {31'd0, hit}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (30) @(negedge clk);
        chk("mid_reset_idle", {31'd0, busy}, 32'd0);
        chk("mid_reset_writes", nwr - base, 2);

        for (int i = 0; i < 256; i++) rom[i] = 16'h3A04;
        run_seq("no_end", 1, 0);
        repeat (10) @(negedge clk);
        chk("no_wrap_sel", {24'd0, rom_sel}, 32'hFF);
        chk("no_wrap_done", {31'd0, done}, 32'd1);

        for (int t = 0; t < 6; t++) begin
            clear_tables();
            len = $urandom_range(24, 1);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(9, 0);
                if (r == 0) begin
                    v = 16'hFFF0;
                end else if (r == 1) begin
                    v = {8'hFF, 8'($urandom_range(239, 0))};
                end else begin
                    v = 16'($urandom);
                    if (v == 16'hFFFF || v == 16'hFFF0) v = 16'h0000;
                end
                rom[i] = v;
            end
            for (int i = 1; i <= 256; i++) nack_plan[i] = ($urandom_range(3, 0) == 0);
            run_seq("random", 1, t[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
        $finish;
    end

endmodule
